// File: rtl/flood_pkg.sv
// Shared types and constants for the flood-fill turn sequencer.
package flood_pkg;

  localparam int MAX_SIZE = 26;
  localparam int COLOR_W  = 3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_READY,
    S_ISSUE,
    S_FILL,
    S_SCAN,
    S_WON,
    S_LOST
  } state_t;

  // Move budget for a game: edge + 2*colors - 1. The caller truncates the
  // result to its counter width.
  function automatic logic [7:0] move_limit(logic [4:0] size, logic [3:0] colors);
    return {3'b000, size} + {3'b000, colors, 1'b0} - 8'd1;
  endfunction

endpackage

// File: rtl/board_scanner.sv
// Row-major board address generator. Held at (0,0) while start is high,
// advances one cell per step, flags the last cell of a size x size board.
module board_scanner
  import flood_pkg::*;
#(
  parameter int MAX_SIZE = flood_pkg::MAX_SIZE
) (
  input  logic       CLOCK,
  input  logic       RESET_N,
  input  logic       start,
  input  logic       step,
  input  logic [4:0] size,
  output logic [4:0] row,
  output logic [4:0] col,
  output logic       last
);

  localparam logic [4:0] MAX_S = 5'(MAX_SIZE);

  logic [4:0] lim;

  // Oversized boards are clamped so the scan never runs past the array.
  always_comb begin
    lim  = ((size > MAX_S) ? MAX_S : size) - 5'd1;
    last = (row == lim) && (col == lim);
  end

  // Address register: restart at the corner, otherwise walk row-major.
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      row <= '0;
      col <= '0;
    end else if (start) begin
      row <= '0;
      col <= '0;
    end else if (step) begin
      if (col == lim) begin
        col <= '0;
        row <= row + 5'd1;
      end else begin
        col <= col + 5'd1;
      end
    end
  end

endmodule

// File: rtl/turn_sequencer.sv
// Turn sequencer: starts a game, qualifies player presses, hands each move
// to the fill engine, then scans the board to decide win / loss / continue.
module turn_sequencer
  import flood_pkg::*;
#(
  parameter int MAX_SIZE = 26,
  parameter int MOVE_W   = 6
) (
  input  logic               CLOCK,
  input  logic               RESET_N,
  input  logic               NEW_GAME,
  input  logic [4:0]         SIZE,
  input  logic [3:0]         COLOR_NUM,
  input  logic               BTN_VALID,
  input  logic [2:0]         BTN_COLOR,
  output logic               BEGIN_GAME,
  input  logic               STARTED_GAME,
  output logic [2:0]         COLOR_SELECTED,
  output logic               COLOR_SEL_SIG,
  input  logic               CHANGING_COLOR,
  output logic [4:0]         SCAN_ROW,
  output logic [4:0]         SCAN_COL,
  input  logic [2:0]         SCAN_COLOR,
  output logic [MOVE_W-1:0]  MOVE_COUNT,
  output logic [MOVE_W-1:0]  MOVES_LEFT,
  output logic               GAME_WON,
  output logic               GAME_LOST,
  output logic               BUSY
);

  state_t              state, nxt;
  logic [4:0]          size_q;
  logic [3:0]          colors_q;
  logic [COLOR_W-1:0]  corner;
  logic [COLOR_W-1:0]  color_sel;
  logic [MOVE_W-1:0]   move_cnt, moves_left;
  logic                scan_first, scan_last, scan_start, scan_step, accept;
  logic                won_q, lost_q;

  // Scanner is held at the corner whenever the next state is not SCAN, so
  // READY always looks at (0,0) and an aborted scan restarts cleanly.
  board_scanner #(.MAX_SIZE(MAX_SIZE)) u_scan (
    .CLOCK   (CLOCK),
    .RESET_N (RESET_N),
    .start   (scan_start),
    .step    (scan_step),
    .size    (size_q),
    .row     (SCAN_ROW),
    .col     (SCAN_COL),
    .last    (scan_last)
  );

  // State register.
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) state <= S_IDLE;
    else          state <= nxt;
  end

  // Next-state and handshake outputs. NEW_GAME overrides everything.
  always_comb begin
    nxt        = state;
    accept     = 1'b0;
    scan_step  = 1'b0;
    BEGIN_GAME    = (state == S_START);
    COLOR_SEL_SIG = (state == S_ISSUE);
    BUSY = (state == S_START) || (state == S_ISSUE) ||
           (state == S_FILL)  || (state == S_SCAN);
    if (NEW_GAME) begin
      nxt = S_START;
    end else begin
      case (state)
        S_START: if (STARTED_GAME) nxt = S_READY;
        S_READY: begin
          if (BTN_VALID && ({1'b0, BTN_COLOR} < colors_q) && (BTN_COLOR != SCAN_COLOR)) begin
            accept = 1'b1;
            nxt    = S_ISSUE;
          end
        end
        S_ISSUE: if (CHANGING_COLOR)  nxt = S_FILL;
        S_FILL:  if (!CHANGING_COLOR) nxt = S_SCAN;
        S_SCAN: begin
          // First scan cycle only captures the corner colour.
          if (!scan_first) begin
            if (SCAN_COLOR != corner)
              nxt = (moves_left == '0) ? S_LOST : S_READY;
            else if (scan_last)
              nxt = S_WON;
            else
              scan_step = 1'b1;
          end
        end
        default: ;
      endcase
    end
    scan_start = (nxt != S_SCAN);
  end

  // Game setup, move counters and selected colour.
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      size_q     <= '0;
      colors_q   <= '0;
      move_cnt   <= '0;
      moves_left <= '0;
      color_sel  <= '0;
    end else if (NEW_GAME) begin
      size_q     <= SIZE;
      colors_q   <= COLOR_NUM;
      move_cnt   <= '0;
      moves_left <= MOVE_W'(move_limit(SIZE, COLOR_NUM));
      color_sel  <= '0;
    end else if (accept) begin
      color_sel <= BTN_COLOR;
      if (move_cnt != '1)   move_cnt   <= move_cnt + 1'b1;
      if (moves_left != '0) moves_left <= moves_left - 1'b1;
    end
  end

  // Scan bookkeeping: first-cycle flag and captured corner colour.
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      scan_first <= 1'b0;
      corner     <= '0;
    end else begin
      scan_first <= (nxt == S_SCAN) && (state != S_SCAN);
      if (state == S_SCAN && scan_first) corner <= SCAN_COLOR;
    end
  end

  // Registered result flags; they follow the terminal states, so they stay
  // set until NEW_GAME moves the FSM to START.
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      won_q  <= 1'b0;
      lost_q <= 1'b0;
    end else begin
      won_q  <= (nxt == S_WON);
      lost_q <= (nxt == S_LOST);
    end
  end

  assign COLOR_SELECTED = color_sel;
  assign MOVE_COUNT     = move_cnt;
  assign MOVES_LEFT     = moves_left;
  assign GAME_WON       = won_q;
  assign GAME_LOST      = lost_q;

endmodule

// File: doc/turn_sequencer.md
TURN_SEQUENCER -- requirements
Module: turn_sequencer

Interface
REQ-001 SHALL have parameter MAX_SIZE, default 26, maximum board edge in cells.
REQ-002 SHALL have parameter MOVE_W, default 6, width of the move counters.
REQ-003 SHALL have port CLOCK  in  1  single system clock; all logic on its rising edge.
REQ-004 SHALL have port RESET_N  in  1  asynchronous, active-low reset.
REQ-005 SHALL have port NEW_GAME  in  1  one-cycle request to start a game.
REQ-006 SHALL have port SIZE  in  5  board edge, one of 2/6/10/14/18/22/26; sampled only on NEW_GAME.
REQ-007 SHALL have port COLOR_NUM  in  4  colors in play, 2..8; sampled only on NEW_GAME.
REQ-008 SHALL have port BTN_VALID  in  1  one-cycle pulse qualifying BTN_COLOR.
REQ-009 SHALL have port BTN_COLOR  in  3  player's chosen color.
REQ-010 SHALL have port BEGIN_GAME  out  1  start request to the fill engine.
REQ-011 SHALL have port STARTED_GAME  in  1  fill engine start acknowledge.
REQ-012 SHALL have port COLOR_SELECTED  out  3  color issued to the fill engine.
REQ-013 SHALL have port COLOR_SEL_SIG  out  1  fill request.
REQ-014 SHALL have port CHANGING_COLOR  in  1  fill engine busy/acknowledge.
REQ-015 SHALL have ports SCAN_ROW, SCAN_COL  out  5 each  board read address.
REQ-016 SHALL have port SCAN_COLOR  in  3  board cell at the scan address, combinational, same cycle.
REQ-017 SHALL have ports MOVE_COUNT and MOVES_LEFT  out  MOVE_W each  moves used and moves remaining.
REQ-018 SHALL have ports GAME_WON, GAME_LOST, BUSY  out  1 each  status flags.

Function
REQ-019 States SHALL be IDLE, START, READY, ISSUE, FILL, SCAN, WON, LOST.
REQ-020 On NEW_GAME in any state: latch SIZE/COLOR_NUM, clear counters and flags, raise BEGIN_GAME, enter START; NEW_GAME wins over a simultaneous BTN_VALID.
REQ-021 START SHALL hold BEGIN_GAME high until STARTED_GAME=1, then drop it and enter READY.
REQ-022 Move limit SHALL be SIZE + 2*COLOR_NUM - 1, computed at MOVE_W bits; example: 14/6 gives 25.
REQ-023 In READY, SCAN_ROW=SCAN_COL=0.
REQ-024 In READY, a BTN_VALID is rejected when BTN_COLOR >= COLOR_NUM or BTN_COLOR == SCAN_COLOR; a rejected press costs no move.
REQ-025 A BTN_VALID outside READY SHALL be ignored.
REQ-026 An accepted press SHALL latch COLOR_SELECTED, increment MOVE_COUNT, decrement MOVES_LEFT, and enter ISSUE.
REQ-027 ISSUE SHALL hold COLOR_SEL_SIG high until CHANGING_COLOR=1, then drop it and enter FILL.
REQ-028 FILL SHALL wait for CHANGING_COLOR=0, then enter SCAN with address (0,0).
REQ-029 SCAN SHALL register the corner color in its first cycle, then step row-major one cell per cycle over SIZE x SIZE.
REQ-030 The first cell differing from the corner SHALL abort the scan: to LOST if MOVES_LEFT=0, else to READY.
REQ-031 A completed scan with all cells matching SHALL enter WON.
REQ-032 A complete scan SHALL take SIZE*SIZE+1 cycles; 677 cycles for size 26.
REQ-033 Win SHALL take priority over loss on the final move.
REQ-034 GAME_WON/GAME_LOST SHALL be registered, set on entering WON/LOST, and held until NEW_GAME or reset.
REQ-035 BUSY SHALL be 1 in START, ISSUE, FILL and SCAN.
REQ-036 MOVE_COUNT SHALL saturate at 2^MOVE_W-1; MOVES_LEFT SHALL never underflow.

Reset
REQ-037 RESET_N low SHALL force IDLE asynchronously, independent of CLOCK.
REQ-038 During reset, every output SHALL be 0, including COLOR_SELECTED, SCAN_ROW/SCAN_COL and both counters.
REQ-039 Reset deassertion mid-fill SHALL leave the block in IDLE, awaiting NEW_GAME; it SHALL NOT reissue a fill.

Structure
REQ-040 A shared package flood_pkg SHALL hold the state encoding, MAX_SIZE, the color width (3) and the move-limit function.
REQ-041 Scan addressing SHALL live in a sub-module board_scanner.
REQ-042 board_scanner SHALL have inputs start and size and outputs row, col, last.

Verification
REQ-043 Bench SHALL cover start handshake: NEW_GAME with SIZE=14, COLOR_NUM=6; STARTED_GAME returned 3 cycles later -> BEGIN_GAME high exactly until then, MOVES_LEFT=25, READY.
REQ-044 Bench SHALL cover rejected presses: BTN_COLOR=6 with COLOR_NUM=6, and BTN_COLOR equal to the corner color -> no COLOR_SEL_SIG, MOVE_COUNT=0.
REQ-045 Bench SHALL cover a normal move: model acks CHANGING_COLOR after 2 cycles, busy 50 cycles, board not uniform -> COLOR_SEL_SIG dropped on ack, MOVE_COUNT=1, back to READY.
REQ-046 Bench SHALL cover a win: size 2, uniform board after fill -> WON after 5 scan cycles, GAME_WON=1 and held.
REQ-047 Bench SHALL cover a final-move loss vs. win: MOVES_LEFT=1 and a non-uniform board -> GAME_LOST=1; same move with a uniform board -> GAME_WON=1 only.
REQ-048 Bench SHALL cover reset/restart: RESET_N low during FILL -> all outputs 0 immediately; NEW_GAME mid-SCAN -> START, counters cleared.
